mem_8x8: RTL and testbench



---
 rtl/mem_pkg.sv | 10 +
 rtl/mem_rd_reg.sv | 27 ++
 rtl/mem_8x8.sv | 57 +++++
 tb/tb_mem_8x8.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the mem_8x8 scratch/config register file.
package mem_pkg;

  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 3;
  localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;

  typedef logic [MEM_DATA_W-1:0] mem_word_t;

endpackage

// File: rtl/mem_rd_reg.sv
// Read-data output register: cleared by reset, loaded on a read, otherwise holds.
module mem_rd_reg
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;

  // Capture the selected word only when a read is granted; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/mem_8x8.sv
// Single-port register-file memory with registered reads and a full synchronous clear.
// Writes take priority over reads and never forward into Dataout.
module mem_8x8
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] Datain,
  output logic [DATA_W-1:0] Dataout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_rdLoad;
  logic [DATA_W-1:0] w_rdData;

  // Storage array: flops rather than a RAM macro so the whole array can clear in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr) begin
      r_mem[addr] <= Datain;
    end
  end

  // A read only loads Dataout when no write competes for the shared address.
  always_comb begin
    w_rdLoad = rd && !wr;
    w_rdData = r_mem[addr];
  end

  mem_rd_reg #(
    .DATA_W (DATA_W)
  ) u_rdReg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_rdLoad),
    .i_data (w_rdData),
    .o_data (Dataout)
  );

  // Dataout must not move on an edge without a granted read (no read, or a write won).
  assert property (@(posedge clk) (!rst && (!rd || wr)) |=> $stable(Dataout));

  // Record that the write-wins collision case is actually exercised.
  cover property (@(posedge clk) !rst && wr && rd);

endmodule

// File: tb/tb_mem_8x8.sv
// Self-checking bench for mem_8x8: array-based reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_mem_8x8;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [2:0] addr;
  logic [7:0] Datain;
  logic [7:0] Dataout;

  logic [7:0] modelMem [8];
  logic [7:0] modelOut;
  logic       modelValid;

  int checkCount;
  int passCount;

  mem_8x8 dut (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .rd      (rd),
    .addr    (addr),
    .Datain  (Datain),
    .Dataout (Dataout)
  );

  // Free-running clock; inputs change on falling edges, outputs are sampled there too.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: Dataout=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: behaviour of a memory with reset > write > read priority.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) modelMem[i] = 8'h00;
      modelOut   = 8'h00;
      modelValid = 1'b1;
    end else if (wr) begin
      modelMem[addr] = Datain;
    end else if (rd) begin
      modelOut = modelMem[addr];
    end
  end

  // Cycle-by-cycle comparison against the model once reset has defined the state.
  always @(negedge clk) begin
    if (modelValid) begin
      check("model", Dataout, modelOut);
    end
  end

  task automatic applyStimulus(input logic iRst, input logic iWr, input logic iRd,
                               input logic [2:0] iAddr, input logic [7:0] iData);
    rst    = iRst;
    wr     = iWr;
    rd     = iRd;
    addr   = iAddr;
    Datain = iData;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expected);
    check(name, Dataout, expected);
  endtask

  initial begin
    logic [7:0] sweepVal;
    checkCount = 0;
    passCount  = 0;
    modelValid = 1'b0;
    modelOut   = 8'h00;
    rst        = 1'b1;
    wr         = 1'b0;
    rd         = 1'b0;
    addr       = 3'd0;
    Datain     = 8'h00;
    @(negedge clk);
    checkOutput("resetOut", 8'h00);

    applyStimulus(0, 0, 0, 3'd0, 8'h00);
    checkOutput("idleAfterReset", 8'h00);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 1, 3'(a), 8'h00);
      checkOutput("readCleared", 8'h00);
    end

    applyStimulus(0, 1, 0, 3'd1, 8'hA5);
    applyStimulus(0, 1, 0, 3'd2, 8'h3C);
    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    checkOutput("read1", 8'hA5);
    applyStimulus(0, 0, 1, 3'd2, 8'h00);
    checkOutput("read2", 8'h3C);
    applyStimulus(0, 1, 0, 3'd3, 8'hFF);
    checkOutput("holdDuringWrite", 8'h3C);
    applyStimulus(0, 0, 1, 3'd3, 8'h00);
    checkOutput("read3", 8'hFF);

    applyStimulus(1, 1, 1, 3'd3, 8'h77);
    checkOutput("resetOverrides", 8'h00);
    applyStimulus(0, 0, 1, 3'd3, 8'h00);
    checkOutput("read3AfterReset", 8'h00);

    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    applyStimulus(0, 1, 0, 3'd1, 8'h99);
    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    checkOutput("readAfterWrite", 8'h99);

    applyStimulus(0, 1, 1, 3'd4, 8'h5A);
    checkOutput("wrRdCollision", 8'h99);
    applyStimulus(0, 0, 1, 3'd4, 8'h00);
    checkOutput("read4", 8'h5A);

    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 0, 3'(a), 8'($urandom));
      checkOutput("holdSweep", 8'h5A);
    end
    applyStimulus(0, 0, 1, 3'd4, 8'h00);
    checkOutput("holdKept4", 8'h5A);
    applyStimulus(0, 0, 1, 3'd1, 8'h00);
    checkOutput("holdKept1", 8'h99);

    for (int a = 0; a < 8; a++) begin
      sweepVal = 8'(a) ^ 8'hC3;
      applyStimulus(0, 1, 0, 3'(a), sweepVal);
    end
    for (int a = 7; a >= 0; a--) begin
      sweepVal = 8'(a) ^ 8'hC3;
      applyStimulus(0, 0, 1, 3'(a), 8'h00);
      checkOutput("sweepRead", sweepVal);
    end
    applyStimulus(0, 0, 1, 3'd7, 8'h00);
    checkOutput("topAddr", 8'hC4);
    applyStimulus(0, 0, 1, 3'd0, 8'h00);
    checkOutput("bottomAddr", 8'hC3);

    applyStimulus(0, 0, 0, 3'd0, 8'h00);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
